// File: rtl/uart_pkg.sv
// Constants, frame-format codes and transmit state encoding shared by the UART
// transmitter and receiver.
package uart_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int TICKS_PER_BIT = 16;

    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_EVEN = 2'b11;

    localparam logic [3:0] FRAME_LEN_MIN = 4'd5;
    localparam logic [3:0] FRAME_LEN_MAX = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        DONE
    } tx_state_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len < FRAME_LEN_MIN) begin
            return FRAME_LEN_MIN;
        end
        if (len > FRAME_LEN_MAX) begin
            return FRAME_LEN_MAX;
        end
        return len;
    endfunction

endpackage

// File: rtl/uart_tx_bb.sv
// UART transmitter: sends one word as back-to-back frames, LSB first, each bit
// held TICKS_PER_BIT ticks. Frame format is latched when the word is accepted.
module uart_tx_bb
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = uart_pkg::DATA_WIDTH,
    parameter int TICKS_PER_BIT = uart_pkg::TICKS_PER_BIT
) (
    input  logic                  tx_tick,
    input  logic                  PRESETn,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic [3:0]            frame_length,
    input  logic                  stop_bit,
    input  logic [1:0]            parity,
    output logic                  TX,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int POS_W  = $clog2(DATA_WIDTH + 8);

    tx_state_t             state_reg, state_next;
    logic [TICK_W-1:0]     tick_reg, tick_next;
    logic [3:0]            bit_reg, bit_next;
    logic [POS_W-1:0]      pos_reg, pos_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  par_acc_reg, par_acc_next;
    logic [3:0]            len_reg, len_next;
    logic                  par_en_reg, par_en_next;
    logic                  par_odd_reg, par_odd_next;
    logic                  two_stop_reg, two_stop_next;
    logic                  tx_reg, tx_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  bit_end;
    logic                  word_sent;

    always_ff @(posedge tx_tick or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg    <= IDLE;
            tick_reg     <= '0;
            bit_reg      <= '0;
            pos_reg      <= '0;
            shift_reg    <= '0;
            par_acc_reg  <= 1'b0;
            len_reg      <= '0;
            par_en_reg   <= 1'b0;
            par_odd_reg  <= 1'b0;
            two_stop_reg <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_reg     <= tick_next;
            bit_reg      <= bit_next;
            pos_reg      <= pos_next;
            shift_reg    <= shift_next;
            par_acc_reg  <= par_acc_next;
            len_reg      <= len_next;
            par_en_reg   <= par_en_next;
            par_odd_reg  <= par_odd_next;
            two_stop_reg <= two_stop_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tick_next     = tick_reg;
        bit_next      = bit_reg;
        pos_next      = pos_reg;
        shift_next    = shift_reg;
        par_acc_next  = par_acc_reg;
        len_next      = len_reg;
        par_en_next   = par_en_reg;
        par_odd_next  = par_odd_reg;
        two_stop_next = two_stop_reg;

        bit_end   = (tick_reg == TICK_W'(TICKS_PER_BIT - 1));
        // pos_reg counts data bits sent including pad, so it reaches the word
        // width only once the final (possibly padded) frame is out.
        word_sent = (pos_reg >= POS_W'(DATA_WIDTH));

        if (state_reg != IDLE && state_reg != DONE) begin
            tick_next = bit_end ? '0 : tick_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                tick_next = '0;
                if (tx_start) begin
                    state_next    = START;
                    shift_next    = tx_data_in;
                    len_next      = clamp_len(frame_length);
                    par_en_next   = parity[1];
                    par_odd_next  = (parity == PAR_ODD);
                    two_stop_next = stop_bit;
                    pos_next      = '0;
                    bit_next      = '0;
                    par_acc_next  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    // Zeros shift in from the top, which supplies the pad bits.
                    par_acc_next = par_acc_reg ^ shift_reg[0];
                    shift_next   = shift_reg >> 1;
                    pos_next     = pos_reg + 1'b1;
                    if (bit_reg == len_reg - 4'd1) begin
                        state_next = par_en_reg ? PARITY : STOP1;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP1;
                end
            end
            STOP1: begin
                if (bit_end) begin
                    if (two_stop_reg) begin
                        state_next = STOP2;
                    end else begin
                        state_next   = word_sent ? DONE : START;
                        par_acc_next = 1'b0;
                    end
                end
            end
            STOP2: begin
                if (bit_end) begin
                    state_next   = word_sent ? DONE : START;
                    par_acc_next = 1'b0;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs follow the state one tick later so every pin is a flop.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_reg != IDLE);
        done_next = (state_reg == DONE);
        case (state_reg)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg[0];
            PARITY:  tx_next = par_odd_reg ? ~par_acc_reg : par_acc_reg;
            default: tx_next = 1'b1;
        endcase
    end

    assign TX      = tx_reg;
    assign tx_busy = busy_reg;
    assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_bb.sv
// Scoreboard bench for uart_tx_bb: expected frames and tx_done times are queued
// by the stimulus and consumed by independent line and done monitors.
`timescale 1ns/1ps
module tb_uart_tx_bb;

    logic        tx_tick      = 1'b0;
    logic        PRESETn      = 1'b0;
    logic        tx_start     = 1'b0;
    logic [31:0] tx_data_in   = '0;
    logic [3:0]  frame_length = 4'd8;
    logic        stop_bit     = 1'b0;
    logic [1:0]  parity       = 2'b00;
    logic        TX;
    logic        tx_busy;
    logic        tx_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         len;
        logic [7:0] data;
        bit         par_en;
        bit         par_bit;
        int         stops;
    } frame_t;

    frame_t frame_q[$];
    int     done_q[$];

    uart_tx_bb dut (
        .tx_tick      (tx_tick),
        .PRESETn      (PRESETn),
        .tx_start     (tx_start),
        .tx_data_in   (tx_data_in),
        .frame_length (frame_length),
        .stop_bit     (stop_bit),
        .parity       (parity),
        .TX           (TX),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    always #5 tx_tick = ~tx_tick;
    always @(posedge tx_tick) cyc <= cyc + 1;

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end else begin
            $display("check %s = %b", name, got);
        end
    endtask

    task automatic push_frame(input int len, input logic [7:0] data, input bit par_en,
                              input bit par_bit, input int stops);
        frame_t f;
        f.len     = len;
        f.data    = data;
        f.par_en  = par_en;
        f.par_bit = par_bit;
        f.stops   = stops;
        frame_q.push_back(f);
    endtask

    // lat = ticks from accept edge to tx_done; 0 means no tx_done expected.
    task automatic start_word(input logic [31:0] d, input logic [3:0] len, input logic [1:0] par,
                              input logic sb, input int lat);
        @(negedge tx_tick);
        tx_data_in   = d;
        frame_length = len;
        parity       = par;
        stop_bit     = sb;
        tx_start     = 1'b1;
        @(negedge tx_tick);
        tx_start = 1'b0;
        if (lat > 0) done_q.push_back(cyc + lat);
        $display("start data=%08h len=%0d par=%b stop=%b at cyc=%0d", d, len, par, sb, cyc);
    endtask

    task automatic wait_word();
        int n = 0;
        while ((frame_q.size() != 0 || done_q.size() != 0 || tx_busy !== 1'b0) && n < 3000) begin
            @(negedge tx_tick);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL word_timeout frames_left=%0d dones_left=%0d exp=0", frame_q.size(), done_q.size());
            frame_q.delete();
            done_q.delete();
        end
        repeat (3) @(negedge tx_tick);
    endtask

    // Line monitor: finds the start bit, samples mid-bit, compares whole frame.
    initial begin : frame_mon
        frame_t      f;
        int          waited;
        int          nb;
        logic [11:0] got;
        logic [11:0] exp;
        forever begin
            @(negedge tx_tick);
            if (frame_q.size() == 0) continue;
            f = frame_q[0];
            waited = 0;
            while (TX !== 1'b0 && waited < 3000) begin
                @(negedge tx_tick);
                waited++;
            end
            if (TX !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL frame_start got=no_start_bit exp=data %02h", f.data);
                void'(frame_q.pop_front());
                continue;
            end
            repeat (8) @(negedge tx_tick);
            got = '0;
            exp = '0;
            got[0] = TX;
            exp[0] = 1'b0;
            nb = 1;
            for (int i = 0; i < f.len; i++) begin
                repeat (16) @(negedge tx_tick);
                got[nb] = TX;
                exp[nb] = f.data[i];
                nb++;
            end
            if (f.par_en) begin
                repeat (16) @(negedge tx_tick);
                got[nb] = TX;
                exp[nb] = f.par_bit;
                nb++;
            end
            for (int s = 0; s < f.stops; s++) begin
                repeat (16) @(negedge tx_tick);
                got[nb] = TX;
                exp[nb] = 1'b1;
                nb++;
            end
            void'(frame_q.pop_front());
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL frame got=%b exp=%b", got, exp);
            end else begin
                $display("frame data=%02h bits=%b", f.data, got);
            end
        end
    end

    // Done monitor: tx_done must land on the predicted tick and release busy next tick.
    initial begin : done_mon
        int exp_c;
        forever begin
            @(negedge tx_tick);
            if (tx_done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected got=cyc %0d exp=none", cyc);
                end else begin
                    exp_c = done_q.pop_front();
                    if (cyc != exp_c || tx_busy !== 1'b1) begin
                        errors++;
                        $display("FAIL done_time got=cyc %0d busy %b exp=cyc %0d busy 1", cyc, tx_busy, exp_c);
                    end else begin
                        $display("done at cyc=%0d", cyc);
                    end
                end
                @(negedge tx_tick);
                checks++;
                if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_release got=done %b busy %b exp=done 0 busy 0", tx_done, tx_busy);
                end
            end
        end
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge tx_tick);
        check_bit("reset_tx", TX, 1'b1);
        check_bit("reset_busy", tx_busy, 1'b0);
        check_bit("reset_done", tx_done, 1'b0);
        PRESETn = 1'b1;
        repeat (2) @(negedge tx_tick);

        // 8N1: 4 frames x 160 ticks
        push_frame(8, 8'h81, 0, 0, 1);
        push_frame(8, 8'h0F, 0, 0, 1);
        push_frame(8, 8'hC3, 0, 0, 1);
        push_frame(8, 8'hA5, 0, 0, 1);
        start_word(32'hA5C3_0F81, 4'd8, 2'b00, 1'b0, 641);
        wait_word();

        // 7E2: 5 frames x 176 ticks, last frame 4 ones + 3 pad zeros
        for (int i = 0; i < 4; i++) push_frame(7, 8'h7F, 1, 1, 2);
        push_frame(7, 8'h0F, 1, 0, 2);
        start_word(32'hFFFF_FFFF, 4'd7, 2'b11, 1'b1, 881);
        wait_word();

        // Length 3 clamps to 5, odd parity over all-zero bits: 7 frames x 128 ticks
        for (int i = 0; i < 7; i++) push_frame(5, 8'h00, 1, 1, 1);
        start_word(32'h0000_0000, 4'd3, 2'b10, 1'b0, 897);
        wait_word();

        // Start pulse mid-word with new data/config is ignored
        push_frame(8, 8'h78, 0, 0, 1);
        push_frame(8, 8'h56, 0, 0, 1);
        push_frame(8, 8'h34, 0, 0, 1);
        push_frame(8, 8'h12, 0, 0, 1);
        start_word(32'h1234_5678, 4'd8, 2'b00, 1'b0, 641);
        repeat (100) @(negedge tx_tick);
        tx_data_in   = 32'hDEAD_BEEF;
        frame_length = 4'd6;
        parity       = 2'b11;
        stop_bit     = 1'b1;
        tx_start     = 1'b1;
        @(negedge tx_tick);
        tx_start = 1'b0;
        wait_word();

        // Next word accepted from IDLE: 6O2, 6 frames x 160 ticks
        push_frame(6, 8'h2F, 1, 0, 2);
        push_frame(6, 8'h3B, 1, 0, 2);
        push_frame(6, 8'h1B, 1, 1, 2);
        push_frame(6, 8'h2B, 1, 1, 2);
        push_frame(6, 8'h1E, 1, 1, 2);
        push_frame(6, 8'h03, 1, 1, 2);
        start_word(32'hDEAD_BEEF, 4'd6, 2'b10, 1'b1, 961);
        wait_word();

        // Reset during frame 2 data bit 4 (a zero) must force TX high at once
        push_frame(8, 8'h81, 0, 0, 1);
        start_word(32'hA5C3_0F81, 4'd8, 2'b00, 1'b0, 0);
        repeat (250) @(negedge tx_tick);
        check_bit("pre_reset_tx", TX, 1'b0);
        #2 PRESETn = 1'b0;
        #1;
        check_bit("abort_tx", TX, 1'b1);
        check_bit("abort_busy", tx_busy, 1'b0);
        check_bit("abort_done", tx_done, 1'b0);
        repeat (2) @(negedge tx_tick);
        PRESETn = 1'b1;
        repeat (2) @(negedge tx_tick);

        // Fresh word after reset, 8N2: 4 frames x 176 ticks
        push_frame(8, 8'h4C, 0, 0, 2);
        push_frame(8, 8'h3D, 0, 0, 2);
        push_frame(8, 8'h2E, 0, 0, 2);
        push_frame(8, 8'h1F, 0, 0, 2);
        start_word(32'h1F2E_3D4C, 4'd8, 2'b01, 1'b1, 705);
        wait_word();

        n = 0;
        while ((frame_q.size() != 0 || done_q.size() != 0) && n < 1000) begin
            @(negedge tx_tick);
            n++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
